// File: rtl/hazard_pkg.sv
// Shared types for the ID-stage hazard unit.
//   slot_t     : shadow copy of one pipeline stage register (EX, MEM or WB)
//   fwd_sel_e  : EX operand source select
//   REG_ZERO   : architectural x0, never a real destination
package hazard_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wb_en;
        logic       late;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       rs1_used;
        logic       rs2_used;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '0;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_MEM  = 2'd1,
        FWD_WB   = 2'd2
    } fwd_sel_e;

    // A slot only produces a value if it holds a real instruction writing a non-zero rd.
    function automatic logic writes_reg(input slot_t s, input logic [4:0] r);
        return s.valid && s.wb_en && (s.rd != REG_ZERO) && (s.rd == r);
    endfunction

endpackage

// File: rtl/hazard_if.sv
// Bundle between pipeline traffic control (master) and the hazard unit (slave).
//   ID fields      : valid, rs1/rs2 (+used), rd, wb_en, late
//   stage controls : ex/mem/wb write enables and bubble requests
//   results        : id_stall, fwd_rs1_sel, fwd_rs2_sel
interface hazard_if
    import hazard_pkg::*;
();
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_rs1_used;
    logic       id_rs2_used;
    logic [4:0] id_rd;
    logic       id_wb_en;
    logic       id_late;
    logic       ex_wr_en;
    logic       mem_wr_en;
    logic       wb_wr_en;
    logic       ex_gen_bubble;
    logic       mem_gen_bubble;
    logic       wb_gen_bubble;
    logic       id_stall;
    fwd_sel_e   fwd_rs1_sel;
    fwd_sel_e   fwd_rs2_sel;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_wb_en, id_late,
        output ex_wr_en, mem_wr_en, wb_wr_en, ex_gen_bubble, mem_gen_bubble, wb_gen_bubble,
        input  id_stall, fwd_rs1_sel, fwd_rs2_sel
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_wb_en, id_late,
        input  ex_wr_en, mem_wr_en, wb_wr_en, ex_gen_bubble, mem_gen_bubble, wb_gen_bubble,
        output id_stall, fwd_rs1_sel, fwd_rs2_sel
    );

endinterface

// File: rtl/hazard_slot.sv
// One shadow slot tracking a pipeline stage register.
//   clk, reset  : pipeline clock, synchronous active-high reset (empties the slot)
//   wr_en       : stage register loads this cycle
//   gen_bubble  : load an empty slot instead of d (only meaningful with wr_en)
//   d / q       : incoming / held slot contents
module hazard_slot
    import hazard_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  wr_en,
    input  logic  gen_bubble,
    input  slot_t d,
    output slot_t q
);

    slot_t q_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= SLOT_EMPTY;
        end else if (wr_en) begin
            q_q <= gen_bubble ? SLOT_EMPTY : d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/hazard_unit.sv
// ID-stage stall and EX operand-forwarding select generation.
//   clk, reset : pipeline clock, synchronous active-high reset
//   hz_if      : slave side of hazard_if (ID fields, stage controls in; stall/selects out)
// Parameters:
//   FORWARD_EN : MEM->EX and WB->EX bypass paths exist
//   WB_BYPASS  : register file writes through, so WB writers never stall ID
module hazard_unit
    import hazard_pkg::*;
#(
    parameter bit FORWARD_EN = 1'b1,
    parameter bit WB_BYPASS  = 1'b1
) (
    input logic     clk,
    input logic     reset,
    hazard_if.slave hz_if
);

    slot_t id_slot;
    slot_t ex_d;
    slot_t ex_q;
    slot_t mem_q;
    slot_t wb_q;

    always_comb begin
        id_slot = '{valid:    hz_if.id_valid,
                    rd:       hz_if.id_rd,
                    wb_en:    hz_if.id_wb_en,
                    late:     hz_if.id_late,
                    rs1:      hz_if.id_rs1,
                    rs2:      hz_if.id_rs2,
                    rs1_used: hz_if.id_rs1_used,
                    rs2_used: hz_if.id_rs2_used};
        ex_d    = hz_if.id_valid ? id_slot : SLOT_EMPTY;
    end

    hazard_slot u_ex_slot (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (hz_if.ex_wr_en),
        .gen_bubble (hz_if.ex_gen_bubble),
        .d          (ex_d),
        .q          (ex_q)
    );

    hazard_slot u_mem_slot (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (hz_if.mem_wr_en),
        .gen_bubble (hz_if.mem_gen_bubble),
        .d          (ex_q),
        .q          (mem_q)
    );

    hazard_slot u_wb_slot (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (hz_if.wb_wr_en),
        .gen_bubble (hz_if.wb_gen_bubble),
        .d          (mem_q),
        .q          (wb_q)
    );

    // Only slot state and ID fields feed this: traffic control derives its controls from
    // id_stall, so any wr_en/bubble term here would close a combinational loop.
    function automatic logic src_stall(input logic [4:0] rs, input logic used,
                                       input slot_t ex, input slot_t mem, input slot_t wb);
        if (!used || rs == REG_ZERO) begin
            return 1'b0;
        end
        if (FORWARD_EN) begin
            return writes_reg(ex, rs) && ex.late;
        end
        return writes_reg(ex, rs) || writes_reg(mem, rs) || (!WB_BYPASS && writes_reg(wb, rs));
    endfunction

    // MEM is checked first since it holds the youngest value.
    function automatic fwd_sel_e src_fwd(input logic [4:0] rs, input logic used,
                                         input logic ex_valid, input slot_t mem,
                                         input slot_t wb);
        if (!FORWARD_EN || !ex_valid || !used || rs == REG_ZERO) begin
            return FWD_NONE;
        end
        if (writes_reg(mem, rs)) begin
            return FWD_MEM;
        end
        if (writes_reg(wb, rs)) begin
            return FWD_WB;
        end
        return FWD_NONE;
    endfunction

    logic late_escape;

    always_comb begin
        hz_if.id_stall = hz_if.id_valid &&
            (src_stall(hz_if.id_rs1, hz_if.id_rs1_used, ex_q, mem_q, wb_q) ||
             src_stall(hz_if.id_rs2, hz_if.id_rs2_used, ex_q, mem_q, wb_q));
        hz_if.fwd_rs1_sel = src_fwd(ex_q.rs1, ex_q.rs1_used, ex_q.valid, mem_q, wb_q);
        hz_if.fwd_rs2_sel = src_fwd(ex_q.rs2, ex_q.rs2_used, ex_q.valid, mem_q, wb_q);

        // A load result still in MEM cannot be bypassed into EX yet.
        late_escape = ex_q.valid && mem_q.late &&
            ((ex_q.rs1_used && writes_reg(mem_q, ex_q.rs1)) ||
             (ex_q.rs2_used && writes_reg(mem_q, ex_q.rs2)));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!late_escape)
            else $error("hazard_unit: load result in MEM consumed by EX (hazard escape)");
        end
    end

    // WB source fields are carried for uniformity but nothing downstream reads them.
    logic unused_wb_fields;
    assign unused_wb_fields = ^{wb_q.late, wb_q.rs1, wb_q.rs2, wb_q.rs1_used, wb_q.rs2_used};

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;
    import hazard_pkg::*;

    logic clk;
    logic reset;

    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_rs1_used;
    logic       id_rs2_used;
    logic [4:0] id_rd;
    logic       id_wb_en;
    logic       id_late;
    logic       ex_wr_en;
    logic       mem_wr_en;
    logic       wb_wr_en;
    logic       ex_gen_bubble;
    logic       mem_gen_bubble;
    logic       wb_gen_bubble;

    int errors = 0;
    int checks = 0;
    int cnt_a, cnt_b, cnt_c;

    // bus[0]: forwarding; bus[1]: no forwarding, no WB bypass; bus[2]: no forwarding, WB bypass
    hazard_if bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_drv
        assign bus[g].id_valid       = id_valid;
        assign bus[g].id_rs1         = id_rs1;
        assign bus[g].id_rs2         = id_rs2;
        assign bus[g].id_rs1_used    = id_rs1_used;
        assign bus[g].id_rs2_used    = id_rs2_used;
        assign bus[g].id_rd          = id_rd;
        assign bus[g].id_wb_en       = id_wb_en;
        assign bus[g].id_late        = id_late;
        assign bus[g].ex_wr_en       = ex_wr_en;
        assign bus[g].mem_wr_en      = mem_wr_en;
        assign bus[g].wb_wr_en       = wb_wr_en;
        assign bus[g].ex_gen_bubble  = ex_gen_bubble;
        assign bus[g].mem_gen_bubble = mem_gen_bubble;
        assign bus[g].wb_gen_bubble  = wb_gen_bubble;
    end

    hazard_unit #(.FORWARD_EN(1'b1), .WB_BYPASS(1'b1)) u_dut_fwd (
        .clk   (clk),
        .reset (reset),
        .hz_if (bus[0])
    );

    hazard_unit #(.FORWARD_EN(1'b0), .WB_BYPASS(1'b0)) u_dut_nofwd (
        .clk   (clk),
        .reset (reset),
        .hz_if (bus[1])
    );

    hazard_unit #(.FORWARD_EN(1'b0), .WB_BYPASS(1'b1)) u_dut_nofwd_byp (
        .clk   (clk),
        .reset (reset),
        .hz_if (bus[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                          input logic wb, input logic late);
        id_valid    = v;
        id_rs1      = rs1;
        id_rs1_used = u1;
        id_rs2      = rs2;
        id_rs2_used = u2;
        id_rd       = rd;
        id_wb_en    = wb;
        id_late     = late;
        #1;
    endtask

    task automatic step(input logic exw, input logic exb, input logic memw, input logic memb,
                        input logic wbw, input logic wbb);
        ex_wr_en       = exw;
        ex_gen_bubble  = exb;
        mem_wr_en      = memw;
        mem_gen_bubble = memb;
        wb_wr_en       = wbw;
        wb_gen_bubble  = wbb;
        @(posedge clk);
        #1;
    endtask

    task automatic adv();
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic bub();
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        set_id(1'b1, 5'd4, 1'b1, 5'd4, 1'b1, 5'd4, 1'b1, 1'b1);
        adv();
        adv();
        reset = 1'b0;
        #1;
        // Reset state: no writers anywhere.
        check_bit("reset_stall_fwd", bus[0].id_stall, 1'b0);
        check_bit("reset_stall_nofwd", bus[1].id_stall, 1'b0);
        check_int("reset_fwd1", int'(bus[0].fwd_rs1_sel), int'(FWD_NONE));
        check_int("reset_fwd2", int'(bus[0].fwd_rs2_sel), int'(FWD_NONE));

        // Load-use: lw x5 then add reading x5.
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        adv();
        set_id(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd8, 1'b1, 1'b0);
        check_bit("lu_stall_fwd", bus[0].id_stall, 1'b1);
        check_bit("lu_stall_nofwd", bus[1].id_stall, 1'b1);
        bub();
        check_bit("lu_release_fwd", bus[0].id_stall, 1'b0);
        check_bit("lu_mem_stall_nofwd", bus[1].id_stall, 1'b1);
        check_bit("lu_mem_stall_nofwd_byp", bus[2].id_stall, 1'b1);
        adv();
        check_int("lu_fwd1_wb", int'(bus[0].fwd_rs1_sel), int'(FWD_WB));
        check_int("lu_fwd2_none", int'(bus[0].fwd_rs2_sel), int'(FWD_NONE));
        check_int("lu_fwd1_nofwd", int'(bus[1].fwd_rs1_sel), int'(FWD_NONE));
        // ID invalid but reading x5 while WB still holds the load.
        set_id(1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        check_bit("invalid_id_no_stall", bus[1].id_stall, 1'b0);

        // ALU chain: add x3, then consumer reading rs2=x3.
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        adv();
        set_id(1'b1, 5'd10, 1'b1, 5'd3, 1'b1, 5'd11, 1'b1, 1'b0);
        check_bit("alu_no_stall_fwd", bus[0].id_stall, 1'b0);
        check_bit("alu_stall_nofwd", bus[1].id_stall, 1'b1);
        adv();
        check_int("alu_fwd2_mem", int'(bus[0].fwd_rs2_sel), int'(FWD_MEM));
        check_int("alu_fwd1_none", int'(bus[0].fwd_rs1_sel), int'(FWD_NONE));
        // add x3, add x3, consumer: MEM must win over WB.
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        adv();
        adv();
        set_id(1'b1, 5'd10, 1'b1, 5'd3, 1'b1, 5'd11, 1'b1, 1'b0);
        check_bit("prio_no_stall", bus[0].id_stall, 1'b0);
        adv();
        check_int("prio_fwd2_mem", int'(bus[0].fwd_rs2_sel), int'(FWD_MEM));

        // x0 writer (marked late) followed by a reader of x0.
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        adv();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd12, 1'b1, 1'b0);
        check_bit("x0_stall_fwd", bus[0].id_stall, 1'b0);
        check_bit("x0_stall_nofwd", bus[1].id_stall, 1'b0);
        adv();
        check_int("x0_fwd1", int'(bus[0].fwd_rs1_sel), int'(FWD_NONE));
        check_int("x0_fwd2", int'(bus[0].fwd_rs2_sel), int'(FWD_NONE));

        // Flush: lw x7 stalls a reader of x7, then EX and MEM are flushed.
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        adv();
        set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0);
        check_bit("flush_pre_stall", bus[0].id_stall, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check_bit("flush_stall_fwd", bus[0].id_stall, 1'b0);
        check_bit("flush_stall_nofwd", bus[1].id_stall, 1'b0);
        adv();
        check_int("flush_fwd1_none", int'(bus[0].fwd_rs1_sel), int'(FWD_NONE));

        // No forwarding: add x9 then dependent read; count stall cycles.
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
        adv();
        set_id(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 1'b0);
        check_bit("nofwd_stall_start", bus[1].id_stall, 1'b1);
        // All enables low with bubbles high: slots must hold.
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        check_bit("hold_stall_nofwd", bus[1].id_stall, 1'b1);
        cnt_a = 0;
        cnt_b = 0;
        cnt_c = 0;
        for (int i = 0; i < 8 && bus[1].id_stall; i++) begin
            cnt_a += int'(bus[0].id_stall);
            cnt_b += int'(bus[1].id_stall);
            cnt_c += int'(bus[2].id_stall);
            bub();
        end
        check_bit("nofwd_stall_release", bus[1].id_stall, 1'b0);
        check_int("nofwd_cycles", cnt_b, 3);
        check_int("nofwd_byp_cycles", cnt_c, 2);
        check_int("fwd_alu_cycles", cnt_a, 0);

        // Reset mid-operation with every slot a writer of x4.
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0);
        adv();
        adv();
        set_id(1'b1, 5'd4, 1'b1, 5'd4, 1'b1, 5'd4, 1'b1, 1'b0);
        adv();
        check_int("pre_reset_fwd1", int'(bus[0].fwd_rs1_sel), int'(FWD_MEM));
        check_bit("pre_reset_stall_nofwd", bus[1].id_stall, 1'b1);
        reset = 1'b1;
        adv();
        reset = 1'b0;
        #1;
        check_bit("mid_reset_stall_fwd", bus[0].id_stall, 1'b0);
        check_bit("mid_reset_stall_nofwd", bus[1].id_stall, 1'b0);
        check_bit("mid_reset_stall_nofwd_byp", bus[2].id_stall, 1'b0);
        check_int("mid_reset_fwd1", int'(bus[0].fwd_rs1_sel), int'(FWD_NONE));
        check_int("mid_reset_fwd2", int'(bus[0].fwd_rs2_sel), int'(FWD_NONE));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
